// File: rtl/wb32_to_wb8_bridge.sv
// Splits one 32-bit Wishbone access into ascending 8-bit lane accesses and returns one ack.
// Optional ack timeout: define WB8_BRIDGE_TIMEOUT_EN.
module wb32_to_wb8_bridge #(
    parameter int ADDRWIDTH = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 I_wb_clk,
    input  logic                 I_reset_n,
    input  logic [ADDRWIDTH-1:0] I_wb_adr,
    input  logic [31:0]          I_wb_dat,
    input  logic [3:0]           I_wb_sel,
    input  logic                 I_wb_stb,
    input  logic                 I_wb_we,
    output logic                 O_wb_ack,
    output logic [31:0]          O_wb_dat,
    output logic                 O_wb_err,
    output logic [ADDRWIDTH-1:0] O_wb8_adr,
    output logic [7:0]           O_wb8_dat,
    output logic                 O_wb8_stb,
    output logic                 O_wb8_we,
    input  logic                 I_wb8_ack,
    input  logic [7:0]           I_wb8_dat
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state_reg;
    logic [ADDRWIDTH-3:0]   adr_reg;
    logic [31:0]            dat_reg;
    logic [3:0]             sel_reg;
    logic                   we_reg;
    logic [1:0]             lane_reg;
    logic [31:0]            acc_reg;

    logic [1:0]             first_lane;
    logic [1:0]             next_lane;
    logic                   next_found;
    logic [31:0]            acc_next;
    logic [7:0]             wr_byte [4];
    logic                   timeout_hit;
    logic [1:0]             adr_lane_unused;

    assign adr_lane_unused = I_wb_adr[1:0];

    // Accumulator merge and write-byte selection, one slice per lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign acc_next[8*gi +: 8] = (!we_reg && lane_reg == 2'(gi)) ? I_wb8_dat
                                                                       : acc_reg[8*gi +: 8];
            assign wr_byte[gi] = dat_reg[8*gi +: 8];
        end
    endgenerate

    // Descending scan so the lowest qualifying lane wins
    always_comb begin
        first_lane = 2'd0;
        next_lane  = 2'd0;
        next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (I_wb_sel[i]) begin
                first_lane = 2'(i);
            end
            if (sel_reg[i] && (2'(i) > lane_reg)) begin
                next_lane  = 2'(i);
                next_found = 1'b1;
            end
        end
    end

`ifdef WB8_BRIDGE_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_reg;
    logic          err_reg;

    // Fires on the WAIT cycle in which the count would reach TIMEOUT
    assign timeout_hit = (state_reg == WAIT) && !I_wb8_ack && (tmo_cnt_reg == CW'(TIMEOUT - 1));
    assign O_wb_err    = err_reg;

    always_ff @(posedge I_wb_clk) begin
        if (!I_reset_n) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= timeout_hit;
            if (state_reg == ISSUE) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == WAIT && !I_wb8_ack) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign O_wb_err    = 1'b0;
`endif

    always_ff @(posedge I_wb_clk) begin
        if (!I_reset_n) begin
            state_reg <= IDLE;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            lane_reg  <= '0;
            acc_reg   <= '0;
            O_wb_ack  <= 1'b0;
            O_wb_dat  <= '0;
            O_wb8_adr <= '0;
            O_wb8_dat <= '0;
            O_wb8_stb <= 1'b0;
            O_wb8_we  <= 1'b0;
        end else begin
            O_wb_ack  <= 1'b0;
            O_wb8_stb <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (I_wb_stb) begin
                        adr_reg <= I_wb_adr[ADDRWIDTH-1:2];
                        dat_reg <= I_wb_dat;
                        sel_reg <= I_wb_sel;
                        we_reg  <= I_wb_we;
                        acc_reg <= '0;
                        if (I_wb_sel != 4'b0000) begin
                            lane_reg  <= first_lane;
                            O_wb8_stb <= 1'b1;
                            O_wb8_adr <= {I_wb_adr[ADDRWIDTH-1:2], first_lane};
                            O_wb8_dat <= I_wb_dat[{first_lane, 3'b000} +: 8];
                            O_wb8_we  <= I_wb_we;
                            state_reg <= ISSUE;
                        end else begin
                            O_wb_ack  <= 1'b1;
                            O_wb_dat  <= '0;
                            state_reg <= DONE;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (I_wb8_ack) begin
                        acc_reg <= acc_next;
                        if (next_found) begin
                            lane_reg  <= next_lane;
                            O_wb8_stb <= 1'b1;
                            O_wb8_adr <= {adr_reg, next_lane};
                            O_wb8_dat <= wr_byte[next_lane];
                            O_wb8_we  <= we_reg;
                            state_reg <= ISSUE;
                        end else begin
                            O_wb_ack  <= 1'b1;
                            O_wb_dat  <= acc_next;
                            state_reg <= DONE;
                        end
                    end else if (timeout_hit) begin
                        O_wb_dat  <= acc_reg;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
